// File: rtl/math_rp_pkg.sv
// Shared types, constants and the golden function for the math_rp exerciser.
package math_rp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_DRAIN,
      ST_DONE
   } state_t;

   // Fibonacci taps 8,6,5,4 expressed as a mask over state bits [7:0].
   localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

   // One in-flight vector: its operands and the result it must produce.
   typedef struct packed {
      logic       valid;
      logic [3:0] a;
      logic [3:0] b;
      logic [8:0] expected;
   } tag_t;

   // Golden RP function: 2*a + b (at most 45, so it always fits in 8 bits).
   function automatic logic [7:0] math_rp_expected(input logic [3:0] a, input logic [3:0] b);
      return {3'b000, a, 1'b0} + {4'b0000, b};
   endfunction

endpackage

// File: rtl/math_rp_lfsr8.sv
// 8-bit Fibonacci LFSR supplying operand pairs in random mode.
module math_rp_lfsr8
   import math_rp_pkg::*;
(
   input  logic       clk,
   input  logic       reset_vio,
   input  logic       load,
   input  logic [7:0] seed,
   input  logic       advance,
   output logic [7:0] state
);

   logic feedback;

   assign feedback = ^(state & LFSR_TAPS);

   // Load the seed on request, otherwise step once per advance.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset_vio) begin
         state <= seed;
      end else if (load) begin
         state <= seed;
      end else if (advance) begin
         state <= {state[6:0], feedback};
      end
   end

endmodule

// File: rtl/math_rp_exerciser.sv
// Drives operand pairs into the math_rp partition and checks each registered
// result against 2*in1 + in2, keeping an error count and the first failure.
module math_rp_exerciser
   import math_rp_pkg::*;
#(
   parameter int         LATENCY   = 1,
   parameter logic [7:0] LFSR_SEED = 8'h01
) (
   input  logic        clk,
   input  logic        reset_vio,
   input  logic        start,
   input  logic        mode,
   input  logic [7:0]  count,
   output logic [3:0]  in1,
   output logic [3:0]  in2,
   input  logic [7:0]  out,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] err_count,
   output logic [3:0]  fail_in1,
   output logic [3:0]  fail_in2,
   output logic [7:0]  fail_got
);

   localparam logic [7:0] DRAIN_LAST = 8'(LATENCY - 1);

   state_t      state_q, state_d;
   logic        launch, drive_en;
   logic        mode_q, rearm_q;
   logic [7:0]  cnt_q;
   logic [7:0]  lfsr_state, vec;
   tag_t        new_tag, tail;
   tag_t        sr_q [0:LATENCY];
   logic        mismatch;

   math_rp_lfsr8 u_lfsr (
      .clk       (clk),
      .reset_vio (reset_vio),
      .load      (launch),
      .seed      (LFSR_SEED),
      .advance   (drive_en),
      .state     (lfsr_state)
   );

   // The sweep index is the complement of the down-counter (255 -> vector 0).
   assign vec     = mode_q ? lfsr_state : ~cnt_q;
   assign new_tag = '{valid: drive_en, a: vec[7:4], b: vec[3:0],
                      expected: {1'b0, math_rp_expected(vec[7:4], vec[3:0])}};

   // Next-state decode; a restart from DONE needs start to have been seen low first.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_d  = state_q;
      launch   = 1'b0;
      drive_en = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               launch  = 1'b1;
               state_d = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            drive_en = 1'b1;
            if (cnt_q == 8'd0) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (cnt_q == 8'd0) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (start && rearm_q) begin
               launch  = 1'b1;
               state_d = ST_DRIVE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset_vio) state_q <= ST_IDLE;
      else           state_q <= state_d;
   end

   // Vector/drain counter, latched mode and the DONE re-arm flag.
   always_ff @(posedge clk) begin
      if (reset_vio) begin
         cnt_q   <= 8'd0;
         mode_q  <= 1'b0;
         rearm_q <= 1'b0;
      end else if (launch) begin
         cnt_q   <= mode ? count : 8'hFF;
         mode_q  <= mode;
         rearm_q <= 1'b0;
      end else begin
         case (state_q)
            ST_DRIVE: cnt_q <= (cnt_q == 8'd0) ? DRAIN_LAST : cnt_q - 8'd1;
            ST_DRAIN: if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
            ST_DONE:  if (!start) rearm_q <= 1'b1;
            default:  ;
         endcase
      end
   end

   // Registered operands and status flags, one cycle behind the FSM state.
   always_ff @(posedge clk) begin
      if (reset_vio) begin
         in1  <= 4'd0;
         in2  <= 4'd0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_q == ST_DRIVE) || (state_q == ST_DRAIN);
         done <= (state_q == ST_DONE);
         if (drive_en) {in1, in2} <= vec;
      end
   end

   // Expected-value pipeline: stage 0 moves with in1/in2, stage LATENCY lines up with out.
   always_ff @(posedge clk) begin
      // NOTE: this small array is reset so a reset mid-run discards in-flight expected values.
      if (reset_vio) begin
         for (int i = 0; i <= LATENCY; i++) sr_q[i] <= '0;
      end else begin
         sr_q[0] <= new_tag;
         for (int i = 1; i <= LATENCY; i++) sr_q[i] <= sr_q[i-1];
      end
   end

   assign tail = sr_q[LATENCY];
   // An out-of-range golden value could never be met by the 8-bit port, so it also counts.
   assign mismatch = tail.valid &&
                     ((out != {2'b00, tail.expected[5:0]}) || (tail.expected[8:6] != 3'b000));

   // Saturating error count and first-failure capture.
   always_ff @(posedge clk) begin
      if (reset_vio || launch) begin
         err_count <= 16'd0;
         fail_in1  <= 4'd0;
         fail_in2  <= 4'd0;
         fail_got  <= 8'd0;
      end else if (mismatch && (err_count != 16'hFFFF)) begin
         err_count <= err_count + 16'd1;
         if (err_count == 16'd0) begin
            fail_in1 <= tail.a;
            fail_in2 <= tail.b;
            fail_got <= out;
         end
      end
   end

   assign pass = done && (err_count == 16'd0);

endmodule

// File: tb/tb_math_rp_exerciser.sv
// Scoreboard bench: two exercisers (LATENCY 1 and 2) each drive a 1-cycle RP model.
module tb_math_rp_exerciser;

   localparam logic [7:0] SEED = 8'h01;

   typedef struct {
      int edge_no;
      int err;
      int pass;
      int f1;
      int f2;
      int fg;
   } res_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_vio, start, mode;
   logic [7:0]  count;
   bit          fault_en;

   logic [3:0]  in1_a, in2_a, fail_in1_a, fail_in2_a;
   logic [7:0]  out_a, fail_got_a;
   logic        busy_a, done_a, pass_a;
   logic [15:0] err_count_a;

   logic [3:0]  in1_b, in2_b, fail_in1_b, fail_in2_b;
   logic [7:0]  out_b, fail_got_b;
   logic        busy_b, done_b, pass_b;
   logic [15:0] err_count_b;

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   vec_q[$];
   res_t res_a_q[$];
   res_t res_b_q[$];
   logic done_a_prev = 1'b0;
   logic done_b_prev = 1'b0;

   math_rp_exerciser #(.LATENCY(1), .LFSR_SEED(SEED)) dut_a (
      .clk(clk), .reset_vio(reset_vio), .start(start), .mode(mode), .count(count),
      .in1(in1_a), .in2(in2_a), .out(out_a), .busy(busy_a), .done(done_a), .pass(pass_a),
      .err_count(err_count_a), .fail_in1(fail_in1_a), .fail_in2(fail_in2_a), .fail_got(fail_got_a)
   );

   math_rp_exerciser #(.LATENCY(2), .LFSR_SEED(SEED)) dut_b (
      .clk(clk), .reset_vio(reset_vio), .start(start), .mode(mode), .count(count),
      .in1(in1_b), .in2(in2_b), .out(out_b), .busy(busy_b), .done(done_b), .pass(pass_b),
      .err_count(err_count_b), .fail_in1(fail_in1_b), .fail_in2(fail_in2_b), .fail_got(fail_got_b)
   );

   // Reconfigurable-module stand-in: registered 2*a+b, optionally with two planted faults.
   function automatic int rp_model(input int a, input int b, input bit fault);
      if (fault && a == 3 && b == 5)   return 'h0A;
      if (fault && a == 15 && b == 15) return 'h00;
      return 2 * a + b;
   endfunction

   // Polynomial x^8+x^6+x^5+x^4+1: new low bit is the xor of the tapped positions.
   function automatic int lfsr_next(input int s);
      int taps[4] = '{8, 6, 5, 4};
      int fb = 0;
      foreach (taps[t]) fb ^= (s >> (taps[t] - 1)) & 1;
      return ((s << 1) | fb) & 'hFF;
   endfunction

   // Vector k is checked against the model output for the vector present lat-1 cycles later
   // (the last vector is held during drain); done rises n+lat+1 edges after launch.
   function automatic res_t predict(input int v[256], input int n, input int lat,
                                    input bit fault, input int e);
      res_t r;
      r = '{edge_no: e + n + lat + 1, err: 0, pass: 0, f1: 0, f2: 0, fg: 0};
      for (int k = 0; k < n; k++) begin
         int j, a, b, got;
         j   = (k + lat - 1 > n - 1) ? n - 1 : k + lat - 1;
         a   = v[k] >> 4;
         b   = v[k] & 15;
         got = rp_model(v[j] >> 4, v[j] & 15, fault);
         if (got != 2 * a + b) begin
            if (r.err == 0) begin
               r.f1 = a;
               r.f2 = b;
               r.fg = got;
            end
            r.err++;
         end
      end
      r.pass = (r.err == 0) ? 1 : 0;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic compare_result(input string tag, input res_t r, input logic [15:0] err,
                                 input logic pass, input logic [3:0] f1, input logic [3:0] f2,
                                 input logic [7:0] fg);
      check({tag, "_done_edge"}, 32'(cyc), 32'(r.edge_no));
      check({tag, "_err_count"}, 32'(err), 32'(r.err));
      check({tag, "_pass"},      32'(pass), 32'(r.pass));
      check({tag, "_fail_in1"},  32'(f1), 32'(r.f1));
      check({tag, "_fail_in2"},  32'(f2), 32'(r.f2));
      check({tag, "_fail_got"},  32'(fg), 32'(r.fg));
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      out_a <= 8'(rp_model(int'(in1_a), int'(in2_a), fault_en));
      out_b <= 8'(rp_model(int'(in1_b), int'(in2_b), fault_en));
   end

   // Monitor: vectors while busy, results when done rises.
   always @(negedge clk) begin
      if (busy_a && vec_q.size() > 0) check("vector", 32'({in1_a, in2_a}), 32'(vec_q.pop_front()));
      if (done_a && !done_a_prev) begin
         if (res_a_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL done_a_unexpected: done rose at edge %0d with no run pending", cyc);
         end else begin
            compare_result("a", res_a_q.pop_front(), err_count_a, pass_a, fail_in1_a, fail_in2_a, fail_got_a);
         end
      end
      if (done_b && !done_b_prev) begin
         if (res_b_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL done_b_unexpected: done rose at edge %0d with no run pending", cyc);
         end else begin
            compare_result("b", res_b_q.pop_front(), err_count_b, pass_b, fail_in1_b, fail_in2_b, fail_got_b);
         end
      end
      done_a_prev <= done_a;
      done_b_prev <= done_b;
   end

   task automatic flush();
      vec_q.delete();
      res_a_q.delete();
      res_b_q.delete();
   endtask

   // Called at a negedge; start is sampled at the next edge, which is edge e.
   task automatic launch(input bit m, input int cnt, input bit hold, input bit fault, output int e);
      int v[256];
      int n, s;
      n = m ? cnt + 1 : 256;
      s = int'(SEED);
      for (int k = 0; k < n; k++) begin
         v[k] = m ? s : k;
         s = lfsr_next(s);
      end
      e = cyc + 1;
      fault_en = fault;
      for (int k = 0; k < n; k++) vec_q.push_back(v[k]);
      res_a_q.push_back(predict(v, n, 1, fault, e));
      res_b_q.push_back(predict(v, n, 2, fault, e));
      mode  = m;
      count = 8'(cnt);
      start = 1'b1;
      @(negedge clk);
      if (!hold) start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (res_a_q.size() == 0 && res_b_q.size() == 0) break;
      end
      if (res_a_q.size() != 0 || res_b_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL done_timeout: no done within %0d cycles (edge %0d)", budget, cyc);
      end else begin
         check("vectors_drained", 32'(vec_q.size()), 32'd0);
      end
      flush();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_in1"},      32'(in1_a), 32'd0);
      check({tag, "_in2"},      32'(in2_a), 32'd0);
      check({tag, "_busy"},     32'(busy_a), 32'd0);
      check({tag, "_done"},     32'(done_a), 32'd0);
      check({tag, "_pass"},     32'(pass_a), 32'd0);
      check({tag, "_err"},      32'(err_count_a), 32'd0);
      check({tag, "_fail_in1"}, 32'(fail_in1_a), 32'd0);
      check({tag, "_fail_in2"}, 32'(fail_in2_a), 32'd0);
      check({tag, "_fail_got"}, 32'(fail_got_a), 32'd0);
      check({tag, "_b_busy"},   32'(busy_b), 32'd0);
      check({tag, "_b_done"},   32'(done_b), 32'd0);
      check({tag, "_b_err"},    32'(err_count_b), 32'd0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int e;
      reset_vio = 1'b1;
      start     = 1'b0;
      mode      = 1'b0;
      count     = 8'd0;
      fault_en  = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      reset_vio = 1'b0;
      @(negedge clk);

      // Clean sweep (count ignored); the LATENCY=2 instance sees a latency mismatch.
      launch(1'b0, 'h5A, 1'b0, 1'b0, e);
      wait_done(300);
      check("sweep_pass", 32'(pass_a), 32'd1);
      check("sweep_err", 32'(err_count_a), 32'd0);
      check("latmis_nonzero", 32'(err_count_b != 16'd0), 32'd1);
      check("latmis_pass", 32'(pass_b), 32'd0);

      // Sweep against a faulty RP.
      launch(1'b0, 0, 1'b0, 1'b1, e);
      wait_done(300);
      check("fault_err", 32'(err_count_a), 32'd2);
      check("fault_in1", 32'(fail_in1_a), 32'd3);
      check("fault_in2", 32'(fail_in2_a), 32'd5);
      check("fault_got", 32'(fail_got_a), 32'h0A);
      check("fault_pass", 32'(pass_a), 32'd0);

      // Random mode: count 9, single vector, a random length and the full 256-vector run.
      launch(1'b1, 9, 1'b0, 1'b0, e);
      wait_done(40);
      launch(1'b1, 0, 1'b0, 1'b0, e);
      wait_done(40);
      launch(1'b1, int'($urandom_range(1, 254)), 1'b0, 1'b1, e);
      wait_done(300);
      launch(1'b1, 255, 1'b0, 1'b0, e);
      wait_done(300);

      // start pulses while busy must not disturb the sequence or done timing.
      launch(1'b0, 0, 1'b0, 1'b0, e);
      repeat (20) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (200) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(100);

      // start held high through DONE must not restart; drop and re-raise it to restart.
      launch(1'b1, 20, 1'b1, 1'b0, e);
      wait_done(60);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("held_busy_a", 32'(busy_a), 32'd0);
         check("held_done_a", 32'(done_a), 32'd1);
         check("held_busy_b", 32'(busy_b), 32'd0);
         check("held_done_b", 32'(done_b), 32'd1);
      end
      start = 1'b0;
      @(negedge clk);
      launch(1'b1, 6, 1'b0, 1'b1, e);
      wait_done(40);

      // Reset at edge 50 of a faulty sweep, then a clean run from IDLE.
      launch(1'b0, 0, 1'b0, 1'b1, e);
      while (cyc < e + 49) @(negedge clk);
      reset_vio = 1'b1;
      @(negedge clk);
      check_idle_outputs("midreset");
      flush();
      reset_vio = 1'b0;
      @(negedge clk);
      launch(1'b0, 0, 1'b0, 1'b0, e);
      wait_done(300);
      check("post_reset_pass", 32'(pass_a), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/math_rp_exerciser.md
# math_rp_exerciser

Self-checking stimulus initiator for the `math_rp` reconfigurable partition. It drives the `in1`/`in2` operand pair into whichever reconfigurable module is loaded, and compares the registered `out` against the golden function `2*in1 + in2`. It reports pass/fail status and the first failing vector. It sits in the static region next to the RP boundary and is controlled from VIO, so a freshly loaded RM can be checked in-system without the ILA.

## Interface
Parameters:
- `LATENCY`, 1: clk edges from an operand change at the RP inputs to the matching `out`. Range 1–4.
- `LFSR_SEED`, 8'h01: seed for random mode. Must be nonzero.

Ports (one synchronous clock, synchronous active-high reset):
- `clk`  in  1  system clock shared with the RP.
- `reset_vio`  in  1  synchronous, active-high reset.
- `start`  in  1  level; sampled in IDLE only.
- `mode`  in  1  0 = exhaustive sweep, 1 = LFSR random. Sampled with `start`.
- `count`  in  8  number of vectors in random mode minus 1. Ignored in sweep mode.
- `in1`  out  4  operand A to the RP (registered).
- `in2`  out  4  operand B to the RP (registered).
- `out`  in  8  RP result.
- `busy`  out  1  high in DRIVE/DRAIN.
- `done`  out  1  high in DONE.
- `pass`  out  1  valid while `done`: `err_count == 0`.
- `err_count`  out  16  mismatches; saturates at 16'hFFFF.
- `fail_in1`, `fail_in2`  out  4 each  operands of the first mismatch.
- `fail_got`  out  8  RP output observed at the first mismatch.

## Operation
- FSM states: IDLE, DRIVE, DRAIN, DONE.
- **IDLE → DRIVE** on `start=1`:
  - Clear `err_count` and the `fail_*` outputs.
  - Latch `mode`.
  - Load the vector counter N−1: 255 in sweep mode, `count` in random mode.
  - Load the LFSR with `LFSR_SEED`.
- **DRIVE:** one vector per cycle.
  - Sweep mode: `{in1,in2}` = index 0..255, incrementing.
  - Random mode: `{in1,in2}` = current LFSR state. The LFSR is 8-bit Fibonacci, taps 8,6,5,4 (maximal, 255 states) and advances every DRIVE cycle.
  - DRIVE → DRAIN after the last vector.
- **DRAIN:** holds `in1`/`in2` at the last vector for `LATENCY` cycles, then moves to DONE.
- **DONE:** holds its state until `start=0` is followed by `start=1`. That restart behaves as IDLE→DRIVE, so no re-arm through IDLE is needed; `start` is edge-qualified in DONE.
- **Checking:**
  - A valid bit and the expected value (9-bit internal, `2*in1+in2`, max 45) travel through a `LATENCY`-deep shift register alongside each vector.
  - When the valid bit emerges, compare `out` against `{2'b00, expected[5:0]}`. A nonzero `out[7:6]` is a mismatch.
  - On a mismatch, increment `err_count` with saturation. On the first mismatch only, capture `fail_in1`, `fail_in2` and `fail_got`.
- `start` while `busy` is ignored.
- `count=0` in random mode means exactly one vector.

## Timing
- Reset values: `in1=0`, `in2=0`, `busy=0`, `done=0`, `pass=0`, `err_count=0`, `fail_*=0`; FSM in IDLE; shift register cleared.
- Edge numbering, with `start` sampled at edge 0:
  - `in1`/`in2` carry vector k from edge k+1, for k = 0..N−1.
  - `busy` rises at edge 1.
  - Vector k is compared at edge k+1+LATENCY.
  - `busy` falls and `done` rises at edge N+LATENCY+1.
- `pass` and `err_count` are final when `done` rises; no compare occurs after that edge.
- `reset_vio` asserted in any state returns every output to its reset value at that edge and discards in-flight expected values.
- A mismatch on the same cycle that `err_count` is already saturated leaves it at FFFF and does not overwrite `fail_*`.

## Structure
- Package `math_rp_pkg` holds:
  - the FSM state enum;
  - the LFSR tap constant;
  - the golden function `math_rp_expected(a,b)`, returning 8 bits.
- Sub-module `math_rp_lfsr8` (load, advance, 8-bit state) is instantiated once.
- Top-level: FSM, vector counter, expected-value shift register, compare/capture logic.

## Test plan
- **Sweep, correct RP model, LATENCY=1:** `done` at edge 258; `pass=1`; `err_count=0`; `in1`/`in2` step through 0x00..0xFF.
- **Fault injection:** model returns 8'h0A for in1=3, in2=5 (expected 8'h0B) and 8'h00 for in1=15, in2=15 → `err_count=2`, `fail_in1=3`, `fail_in2=5`, `fail_got=8'h0A`, `pass=0`.
- **Random mode, `count=9`, seed 8'h01:** 10 vectors matching the reference LFSR sequence; `done` at edge 12.
- **Latency mismatch:** LATENCY=2 against a 1-cycle model → nonzero `err_count`, `pass=0`.
- **Reset mid-run:** assert `reset_vio` at edge 50 of a sweep → all outputs 0, IDLE. A new `start` gives a clean run with `pass=1`.
- **Restart handling:** pulse `start` while `busy` → no effect on vector sequence or `done` timing. In DONE, `start` must drop and re-rise to restart.
